colour_stack_task: RTL and testbench
====================================

COLOUR_STACK_TASK -- requirements
Module: colour_stack_task

Interface
REQ-001 The block SHALL expose parameter NUM_SQUARES, default 3, meaning the number of stacked squares and button channels (range 1..4).
REQ-002 The block SHALL expose parameter NUM_COLOURS, default 6, meaning the number of colour indices cycled (range 2..6).
REQ-003 The block SHALL expose parameter DEBOUNCE_CYCLES, default 1250000, meaning the per-channel lockout after an accepted press (200 ms at 6.25 MHz).
REQ-004 The block SHALL expose parameters SQ_X0=40, SQ_SIZE=14, SQ_PITCH=15, CX=47, CY=52, R2=43, meaning square and circle geometry in pixels.
REQ-005 The block SHALL expose parameter MATCH_MASK, default 6'b010010, meaning the colour indices that light the indicator circle (red, orange).
REQ-006 clk_mhz_6_25  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset_task  input  1  synchronous, active-high reset.
REQ-008 btn  input  NUM_SQUARES  raw asynchronous push buttons; bit i advances square i (bit 0 = top).
REQ-009 btn_rev  input  1  direction select sampled at press acceptance; 1 = step backward.
REQ-010 x  input  7  current pixel column (0..95).
REQ-011 y  input  6  current pixel row (0..63).
REQ-012 oled_data  output  16  RGB565 pixel colour for (x,y).
REQ-013 match  output  1  high while all squares hold the same index and that index's MATCH_MASK bit is set.
REQ-014 match_pulse  output  1  single-cycle strobe on each 0->1 transition of match.

Function
REQ-015 Each btn bit SHALL pass a 2-flop synchroniser, then a rising-edge detector comparing the synchronised value with its previous-cycle value.
REQ-016 Each channel SHALL own an independent debounce FSM with states READY and LOCKOUT.
REQ-017 In READY, a detected rising edge SHALL update that channel's index on the next clock and enter LOCKOUT with counter loaded to DEBOUNCE_CYCLES-1.
REQ-018 In LOCKOUT, the counter SHALL decrement each cycle, edges SHALL be ignored, and state SHALL return to READY in the cycle after the counter reads 0.
REQ-019 Previous-value tracking SHALL continue in LOCKOUT, so a button held through lockout does not register a new press.
REQ-020 Simultaneous edges on different channels SHALL all be accepted in the same cycle, since lockouts are per-channel, not shared.
REQ-021 Forward step SHALL be idx = (idx == NUM_COLOURS-1) ? 0 : idx+1; backward step SHALL be idx = (idx == 0) ? NUM_COLOURS-1 : idx-1.
REQ-022 Colour map SHALL be 0 white 16'hFFFF, 1 red 16'hF800, 2 green 16'h07E0, 3 blue 16'h001F, 4 orange 16'hFC00, 5 black 16'h0000.
REQ-023 Square i region SHALL be SQ_X0 < x < SQ_X0+SQ_SIZE and i*SQ_PITCH < y < i*SQ_PITCH+SQ_SIZE, with strict bounds.
REQ-024 Circle region SHALL be (x-CX)^2+(y-CY)^2 < R2, evaluated with signed differences of at least 8 bits and a 16-bit unsigned sum.
REQ-025 oled_data SHALL be registered, with 1-cycle latency from x,y to the corresponding pixel.
REQ-026 Pixel priority SHALL be: square region → its colour; else circle region → colour of the matched index if match, else black; else black.
REQ-027 match SHALL be registered and update the cycle after the index change; match_pulse SHALL assert in the same cycle match rises.

Reset
REQ-028 While reset_task is high at a clock edge, all indices SHALL become 0, all FSMs READY, counters 0, synchroniser and prev flops 0, oled_data 16'h0000, match 0, match_pulse 0.
REQ-029 Reset asserted mid-LOCKOUT SHALL abort the lockout, so the first post-reset rising edge is accepted.
REQ-030 A button held high across reset release SHALL NOT count as a press until it is released and pressed again.

Verification
REQ-031 Reset, then drive x=45,y=5 → oled_data=16'hFFFF one cycle later; x=45,y=52 → 16'h0000.
REQ-032 With DEBOUNCE_CYCLES=4, press btn[0] twice within 3 cycles → index 1 only, square 0 red; a press after lockout → green.
REQ-033 Press btn[1] six times forward → index wraps 5→0, white; btn_rev=1 from index 0 → index 5, black.
REQ-034 Press all three btn bits in the same cycle → all indices 1, match=1, match_pulse high exactly one cycle, x=47,y=52 → 16'hF800.
REQ-035 Set all squares to index 2 → match=0, circle pixel black; set all to 4 → circle 16'hFC00.
REQ-036 Assert reset_task during LOCKOUT, then press immediately after release → press accepted and index increments.

Source files
------------

// File: rtl/colour_stack_task.sv
// colour_stack_task
//   Three stacked colour squares, each cycled through a small palette by its
//   own push button, plus an indicator circle that lights when every square
//   shows the same "match" colour.
//
// Ports
//   clk_mhz_6_25  in   sole clock, rising edge
//   reset_task    in   synchronous active-high reset
//   btn           in   raw async buttons, bit i steps square i (bit 0 = top)
//   btn_rev       in   1 = step backward, sampled when a press is accepted
//   x, y          in   current pixel column / row
//   oled_data     out  RGB565 pixel for the previous cycle's (x,y)
//   match         out  all squares equal and that colour is in MATCH_MASK
//   match_pulse   out  one-cycle strobe on each rise of match
//
// Debounce FSM (one per button channel)
//   state      | meaning
//   ST_READY   | waiting for a synchronised rising edge
//   ST_LOCKOUT | press accepted; edges ignored until counter expires
module colour_stack_task #(
  parameter int         NUM_SQUARES     = 3,
  parameter int         NUM_COLOURS     = 6,
  parameter int         DEBOUNCE_CYCLES = 1250000,
  parameter int         SQ_X0           = 40,
  parameter int         SQ_SIZE         = 14,
  parameter int         SQ_PITCH        = 15,
  parameter int         CX              = 47,
  parameter int         CY              = 52,
  parameter int         R2              = 43,
  parameter logic [5:0] MATCH_MASK      = 6'b010010
) (
  input  logic                   clk_mhz_6_25,
  input  logic                   reset_task,
  input  logic [NUM_SQUARES-1:0] btn,
  input  logic                   btn_rev,
  input  logic [6:0]             x,
  input  logic [5:0]             y,
  output logic [15:0]            oled_data,
  output logic                   match,
  output logic                   match_pulse
);

  localparam int             CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  LOAD     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]     LAST_IDX = 3'(NUM_COLOURS - 1);
  localparam logic signed [8:0] L_CX  = 9'(CX);
  localparam logic signed [8:0] L_CY  = 9'(CY);

  typedef enum logic {ST_READY = 1'b0, ST_LOCKOUT = 1'b1} state_t;

  function automatic logic [15:0] f_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    f_colour = 16'hFFFF;
      3'd1:    f_colour = 16'hF800;
      3'd2:    f_colour = 16'h07E0;
      3'd3:    f_colour = 16'h001F;
      3'd4:    f_colour = 16'hFC00;
      default: f_colour = 16'h0000;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------
  logic [NUM_SQUARES-1:0] r_sync1, r_sync2, r_prev, r_armed;
  logic                   r_warm;
  logic [NUM_SQUARES-1:0] w_rise;

  // The synchroniser is cleared by reset, so a button held through reset
  // would otherwise look like a fresh 0->1 edge. A channel is armed only
  // once a genuine post-reset low sample has reached the first flop.
  always_ff @(posedge clk_mhz_6_25) begin
    if (reset_task) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_armed <= '0;
      r_warm  <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_warm  <= 1'b1;
      r_armed <= r_armed | ({NUM_SQUARES{r_warm}} & ~r_sync1);
    end
  end

  assign w_rise = r_sync2 & ~r_prev & r_armed;

  // ---------------------------------------------------------------------
  // Per-channel debounce FSMs
  // ---------------------------------------------------------------------
  state_t                 r_state     [NUM_SQUARES];
  state_t                 w_state_nxt [NUM_SQUARES];
  logic [CW-1:0]          r_cnt       [NUM_SQUARES];
  logic [CW-1:0]          w_cnt_nxt   [NUM_SQUARES];
  logic [NUM_SQUARES-1:0] w_accept;

  always_ff @(posedge clk_mhz_6_25) begin
    for (int i = 0; i < NUM_SQUARES; i++) begin
      if (reset_task) begin
        r_state[i] <= ST_READY;
        r_cnt[i]   <= '0;
      end else begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SQUARES; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        ST_READY: begin
          if (w_rise[i]) begin
            w_state_nxt[i] = ST_LOCKOUT;
            w_cnt_nxt[i]   = LOAD;
          end
        end
        ST_LOCKOUT: begin
          if (r_cnt[i] == '0) begin
            w_state_nxt[i] = ST_READY;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] - 1'b1;
          end
        end
        default: w_state_nxt[i] = ST_READY;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SQUARES; i++) begin
      w_accept[i] = (r_state[i] == ST_READY) && w_rise[i];
    end
  end

  // ---------------------------------------------------------------------
  // Colour indices
  // ---------------------------------------------------------------------
  logic [2:0] r_idx [NUM_SQUARES];

  always_ff @(posedge clk_mhz_6_25) begin
    for (int i = 0; i < NUM_SQUARES; i++) begin
      if (reset_task) begin
        r_idx[i] <= 3'd0;
      end else if (w_accept[i]) begin
        if (btn_rev) begin
          r_idx[i] <= (r_idx[i] == 3'd0) ? LAST_IDX : r_idx[i] - 3'd1;
        end else begin
          r_idx[i] <= (r_idx[i] == LAST_IDX) ? 3'd0 : r_idx[i] + 3'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Match detection
  // ---------------------------------------------------------------------
  logic       w_all_same;
  logic [7:0] w_mask_ext;
  logic       w_match;
  logic       r_match, r_match_pulse;

  always_comb begin
    w_all_same = 1'b1;
    for (int i = 1; i < NUM_SQUARES; i++) begin
      if (r_idx[i] != r_idx[0]) w_all_same = 1'b0;
    end
  end

  // Widened so any 3-bit index selects a defined bit.
  assign w_mask_ext = {2'b00, MATCH_MASK};
  assign w_match    = w_all_same && w_mask_ext[r_idx[0]];

  always_ff @(posedge clk_mhz_6_25) begin
    if (reset_task) begin
      r_match       <= 1'b0;
      r_match_pulse <= 1'b0;
    end else begin
      r_match       <= w_match;
      r_match_pulse <= w_match & ~r_match;
    end
  end

  assign match       = r_match;
  assign match_pulse = r_match_pulse;

  // ---------------------------------------------------------------------
  // Pixel generation
  // ---------------------------------------------------------------------
  logic                w_sq_hit;
  logic [15:0]         w_sq_colour;
  logic signed [8:0]   w_dx, w_dy;
  logic signed [15:0]  w_dx_ext, w_dy_ext;
  logic [15:0]         w_dx2, w_dy2, w_sum;
  logic                w_circle;
  logic [15:0]         r_oled;

  // Descending scan so the lowest-numbered square wins any overlap.
  always_comb begin
    w_sq_hit    = 1'b0;
    w_sq_colour = 16'h0000;
    for (int i = NUM_SQUARES - 1; i >= 0; i--) begin
      if ((int'(x) > SQ_X0) && (int'(x) < SQ_X0 + SQ_SIZE) &&
          (int'(y) > i * SQ_PITCH) && (int'(y) < i * SQ_PITCH + SQ_SIZE)) begin
        w_sq_hit    = 1'b1;
        w_sq_colour = f_colour(r_idx[i]);
      end
    end
  end

  assign w_dx     = $signed({2'b00, x}) - L_CX;
  assign w_dy     = $signed({3'b000, y}) - L_CY;
  assign w_dx_ext = 16'(w_dx);
  assign w_dy_ext = 16'(w_dy);
  assign w_dx2    = w_dx_ext * w_dx_ext;
  assign w_dy2    = w_dy_ext * w_dy_ext;
  assign w_sum    = w_dx2 + w_dy2;
  assign w_circle = (w_sum < 16'(R2));

  always_ff @(posedge clk_mhz_6_25) begin
    if (reset_task) begin
      r_oled <= 16'h0000;
    end else if (w_sq_hit) begin
      r_oled <= w_sq_colour;
    end else if (w_circle && r_match) begin
      r_oled <= f_colour(r_idx[0]);
    end else begin
      r_oled <= 16'h0000;
    end
  end

  assign oled_data = r_oled;

endmodule

// File: tb/tb_colour_stack_task.sv
// Bench for colour_stack_task: directed scenarios plus random presses and
// random pixel probes, checked against a press-level behavioural model.
module tb_colour_stack_task;

  localparam int D = 4;
  localparam logic [15:0] COL [6] = '{16'hFFFF, 16'hF800, 16'h07E0,
                                      16'h001F, 16'hFC00, 16'h0000};
  localparam logic [5:0]  MASK = 6'b010010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  btn = 3'b000;
  logic        rev = 1'b0;
  logic [6:0]  x   = 7'd0;
  logic [5:0]  y   = 6'd0;
  logic [15:0] oled_data;
  logic        match, match_pulse;

  always #80 clk = ~clk;

  colour_stack_task #(.DEBOUNCE_CYCLES(D)) dut (
    .clk_mhz_6_25 (clk),
    .reset_task   (rst),
    .btn          (btn),
    .btn_rev      (rev),
    .x            (x),
    .y            (y),
    .oled_data    (oled_data),
    .match        (match),
    .match_pulse  (match_pulse)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_pulse = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  int m_idx  [3];
  int m_last [3];
  bit m_match = 1'b0;
  int m_rises = 0;

  function automatic bit model_match();
    return (m_idx[0] == m_idx[1]) && (m_idx[1] == m_idx[2]) && MASK[m_idx[0]];
  endfunction

  function automatic logic [15:0] model_pixel(int px, int py);
    for (int i = 0; i < 3; i++)
      if (px > 40 && px < 54 && py > i*15 && py < i*15 + 14) return COL[m_idx[i]];
    if ((px-47)*(px-47) + (py-52)*(py-52) < 43) return m_match ? COL[m_idx[0]] : 16'h0000;
    return 16'h0000;
  endfunction

  // A press raised now is first sampled at the next edge and, if accepted,
  // changes the index two edges later. A channel accepts again only once
  // D+1 edges have passed since its previous acceptance.
  task automatic model_press(input logic [2:0] m, input bit r, input int a);
    bit nm;
    for (int ch = 0; ch < 3; ch++) begin
      if (m[ch] && (a - m_last[ch] >= D + 1)) begin
        m_last[ch] = a;
        if (r) m_idx[ch] = (m_idx[ch] == 0) ? 5 : m_idx[ch] - 1;
        else   m_idx[ch] = (m_idx[ch] == 5) ? 0 : m_idx[ch] + 1;
      end
    end
    nm = model_match();
    if (nm && !m_match) m_rises++;
    m_match = nm;
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 3; ch++) begin
      m_idx[ch]  = 0;
      m_last[ch] = -100;
    end
    m_match = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] oled;
    logic        m;
    int          tag;
  } exp_t;

  exp_t q[$];
  logic stb = 1'b0;
  logic vld = 1'b0;

  always @(posedge clk) vld <= stb;

  always @(negedge clk) begin
    exp_t e;
    if (match_pulse) n_pulse++;
    if (vld) begin
      if (q.size() == 0) begin
        chk("scoreboard_underflow", 1, 0);
      end else begin
        e = q.pop_front();
        chk($sformatf("pixel#%0d", e.tag), int'(oled_data), int'(e.oled));
        chk($sformatf("match#%0d", e.tag), int'(match), int'(e.m));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic probe(input int px, input int py, input int tag);
    exp_t e;
    x = 7'(px);
    y = 6'(py);
    e.oled = model_pixel(px, py);
    e.m    = m_match;
    e.tag  = tag;
    q.push_back(e);
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic press(input logic [2:0] m, input bit r, input int hold, input int gap);
    rev = r;
    btn = m;
    model_press(m, r, cyc + 3);
    tick(hold);
    btn = 3'b000;
    tick(gap);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    x = 7'd45;
    y = 6'd5;
    tick(n);
    chk("reset_oled", int'(oled_data), 0);
    chk("reset_match", int'(match), 0);
    chk("reset_pulse", int'(match_pulse), 0);
    rst = 1'b0;
    model_reset();
    tick(1);
  endtask

  initial begin
    #(160 * 10000);
    $display("FAIL watchdog: time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    int tag;
    logic [2:0] m;
    bit r;
    int px, py, sel;

    model_reset();
    tick(1);
    do_reset(3);
    tick(2);

    // white top square, dark circle after reset
    probe(45, 5, 1);
    probe(45, 52, 2);

    // two presses inside one lockout count once, then one after it
    press(3'b001, 1'b0, 1, 1);
    press(3'b001, 1'b0, 1, D + 3);
    tick(2);
    probe(45, 5, 3);
    press(3'b001, 1'b0, 1, D + 3);
    tick(2);
    probe(45, 5, 4);

    // forward wrap, then backward wrap on square 1
    repeat (6) press(3'b010, 1'b0, 1, D + 2);
    tick(2);
    probe(45, 20, 5);
    press(3'b010, 1'b1, 1, D + 2);
    tick(2);
    probe(45, 20, 6);

    // simultaneous presses, red match
    do_reset(2);
    press(3'b111, 1'b0, 1, D + 2);
    tick(2);
    probe(47, 52, 7);
    chk("pulse_count_red", n_pulse, m_rises);

    // green (no match) then orange (match)
    press(3'b111, 1'b0, 1, D + 2);
    tick(2);
    probe(47, 52, 8);
    probe(45, 35, 9);
    press(3'b111, 1'b0, 1, D + 2);
    press(3'b111, 1'b0, 1, D + 2);
    tick(2);
    probe(47, 52, 10);
    probe(45, 20, 11);

    // button held across reset release is not a press
    btn = 3'b100;
    do_reset(2);
    tick(8);
    probe(45, 37, 12);
    btn = 3'b000;
    tick(2);
    press(3'b100, 1'b0, 1, D + 2);
    tick(2);
    probe(45, 37, 13);

    // reset during lockout, press right after release
    press(3'b001, 1'b0, 1, 1);
    tick(2);
    do_reset(1);
    press(3'b001, 1'b0, 1, D + 2);
    tick(2);
    probe(45, 5, 14);
    chk("pulse_count_mid", n_pulse, m_rises);

    // random presses with interleaved pixel probes
    tag = 100;
    repeat (60) begin
      m = 3'($urandom_range(1, 7));
      r = 1'($urandom_range(0, 1));
      press(m, r, $urandom_range(1, 3), $urandom_range(2, 7));
      if ($urandom_range(0, 2) == 0) begin
        tick(3);
        repeat (3) begin
          sel = $urandom_range(0, 2);
          if (sel == 0) begin
            px = $urandom_range(0, 95);
            py = $urandom_range(0, 63);
          end else if (sel == 1) begin
            px = $urandom_range(39, 55);
            py = $urandom_range(0, 45);
          end else begin
            px = $urandom_range(38, 56);
            py = $urandom_range(44, 63);
          end
          probe(px, py, tag);
          tag++;
        end
      end
    end

    tick(4);
    probe(45, 5, tag);
    probe(45, 20, tag + 1);
    probe(45, 37, tag + 2);
    probe(47, 52, tag + 3);
    tick(3);
    chk("scoreboard_drained", q.size(), 0);
    chk("pulse_count_final", n_pulse, m_rises);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
